// File: rtl/frame_map_if.sv
// -----------------------------------------------------------------------------
// frame_map_if
// Bundles the client payload handshake, the ARQ request, the framing enable
// and the line-side output bus of frame_map. The mapper uses the slave modport,
// the client/serializer side (or a testbench) uses the master modport.
// ROW_W/COL_W must match the row/column counter widths of the mapper instance
// (2 and 11 bits for the default 4 x 1041 frame).
// -----------------------------------------------------------------------------
interface frame_map_if #(
  parameter int ROW_W = 2,
  parameter int COL_W = 11
);
  logic             i_tx_en;
  logic [7:0]       i_pyld_data;
  logic             i_pyld_valid;
  logic             o_pyld_ready;
  logic             i_arq_en;
  logic             i_arq_en_valid;
  logic [7:0]       o_frame_data;
  logic             o_frame_data_valid;
  logic [ROW_W-1:0] o_row_cnt;
  logic [COL_W-1:0] o_col_cnt;
  logic             o_frame_start;

  // Client / serializer side: drives the requests, observes the line bytes.
  modport master (
    output i_tx_en, i_pyld_data, i_pyld_valid, i_arq_en, i_arq_en_valid,
    input  o_pyld_ready, o_frame_data, o_frame_data_valid,
           o_row_cnt, o_col_cnt, o_frame_start
  );

  // Mapper side.
  modport slave (
    input  i_tx_en, i_pyld_data, i_pyld_valid, i_arq_en, i_arq_en_valid,
    output o_pyld_ready, o_frame_data, o_frame_data_valid,
           o_row_cnt, o_col_cnt, o_frame_start
  );
endinterface

// File: rtl/frame_map.sv
// -----------------------------------------------------------------------------
// frame_map
// Transmit-side frame mapper. Builds NUM_ROWS x ROW_LEN line frames:
//   cols 0..OH_COLS-1        overhead (FAS in row 0 cols 0..5, ARQ flag in
//                            row 0 col 6, optional MFAS in row 0 col 7)
//   cols OH_COLS..ROW_LEN-2  client payload, stalls while the client is idle
//   col  ROW_LEN-1           stuff byte 0x00
// Every line-side output is registered; row/col outputs label the byte they
// accompany. i_tx_en is only looked at on frame boundaries, so a frame always
// completes once started (only i_rst aborts it).
//
// Optional feature: define FRAME_MAP_MFAS_EN to send an 8-bit multiframe
// counter in row 0 col 7 (first frame after reset carries 0x00). Without it
// that byte is 0x00 and no counter is built.
//
// Reset: i_rst, synchronous, active-high.
// -----------------------------------------------------------------------------
module frame_map #(
  parameter int         NUM_ROWS = 4,
  parameter int         ROW_LEN  = 1041,
  parameter int         OH_COLS  = 16,
  parameter logic [7:0] FAS_A    = 8'hF6,
  parameter logic [7:0] FAS_B    = 8'h28
) (
  input  logic       i_clk,
  input  logic       i_rst,
  frame_map_if.slave bus
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(ROW_LEN);

  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(NUM_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE       = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE       = COL_W'(1);
  localparam logic [COL_W-1:0] COL_OH_LAST   = COL_W'(OH_COLS - 1);
  localparam logic [COL_W-1:0] COL_PYLD_LAST = COL_W'(ROW_LEN - 2);
  localparam logic [COL_W-1:0] COL_STUFF     = COL_W'(ROW_LEN - 1);
  localparam logic [COL_W-1:0] COL_FAS_B     = COL_W'(3);
  localparam logic [COL_W-1:0] COL_ARQ       = COL_W'(6);
  localparam logic [COL_W-1:0] COL_MFAS      = COL_W'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OH,
    S_PYLD,
    S_STUFF
  } state_t;

  // Slot pointer: row/col of the next byte to be emitted.
  state_t           r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  // ARQ flag: r_arq_hold follows the request, r_arq_frame is frozen per frame.
  logic             r_arq_hold;
  logic             r_arq_frame;

  // Registered line-side outputs.
  logic [7:0]       r_frame_data;
  logic             r_frame_data_valid;
  logic [ROW_W-1:0] r_row_cnt;
  logic [COL_W-1:0] r_col_cnt;
  logic             r_frame_start;

  logic             w_frame_begin;
  logic             w_arq_next;
  logic [7:0]       w_oh_byte;
  logic [7:0]       w_mfas_byte;

  // The row 0 / col 0 slot is being emitted this cycle.
  assign w_frame_begin = (r_state == S_OH) && (r_row == '0) && (r_col == '0);

  // A request arriving in the frame-start cycle wins over the held value.
  assign w_arq_next = bus.i_arq_en_valid ? bus.i_arq_en : r_arq_hold;

  // Ready only while sitting on a payload slot and not in reset.
  assign bus.o_pyld_ready = (r_state == S_PYLD) && !i_rst;

  assign bus.o_frame_data       = r_frame_data;
  assign bus.o_frame_data_valid = r_frame_data_valid;
  assign bus.o_row_cnt          = r_row_cnt;
  assign bus.o_col_cnt          = r_col_cnt;
  assign bus.o_frame_start      = r_frame_start;

`ifdef FRAME_MAP_MFAS_EN
  logic [7:0] r_mfas_cnt;
  logic [7:0] r_mfas_frame;

  // Multiframe counter: freeze the current count for this frame, then step it,
  // so the first frame after reset carries 0x00.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      r_mfas_cnt   <= 8'h00;
      r_mfas_frame <= 8'h00;
    end else if (w_frame_begin) begin
      r_mfas_frame <= r_mfas_cnt;
      r_mfas_cnt   <= r_mfas_cnt + 8'h01;
    end
  end

  assign w_mfas_byte = r_mfas_frame;
`else
  assign w_mfas_byte = 8'h00;
`endif

  // Overhead byte for the current slot; only row 0 carries non-zero content.
  always_comb begin
    // NOTE: default first so every path assigns the byte and no latch is built.
    w_oh_byte = 8'h00;
    if (r_row == '0) begin
      if (r_col < COL_FAS_B) begin
        w_oh_byte = FAS_A;
      end else if (r_col < COL_ARQ) begin
        w_oh_byte = FAS_B;
      end else if (r_col == COL_ARQ) begin
        w_oh_byte = {8{r_arq_frame}};
      end else if (r_col == COL_MFAS) begin
        w_oh_byte = w_mfas_byte;
      end
    end
  end

  // Framing FSM: walks the slot pointer and registers the emitted byte + labels.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state            <= S_IDLE;
      r_row              <= '0;
      r_col              <= '0;
      r_arq_hold         <= 1'b0;
      r_arq_frame        <= 1'b0;
      r_frame_data       <= 8'h00;
      r_frame_data_valid <= 1'b0;
      r_row_cnt          <= '0;
      r_col_cnt          <= '0;
      r_frame_start      <= 1'b0;
    end else begin
      // Default: no byte this cycle; data and labels hold their last value.
      r_frame_data_valid <= 1'b0;
      r_frame_start      <= 1'b0;

      if (bus.i_arq_en_valid) begin
        r_arq_hold <= bus.i_arq_en;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.i_tx_en) begin
            r_row   <= '0;
            r_col   <= '0;
            r_state <= S_OH;
          end
        end

        S_OH: begin
          r_frame_data       <= w_oh_byte;
          r_frame_data_valid <= 1'b1;
          r_row_cnt          <= r_row;
          r_col_cnt          <= r_col;
          r_frame_start      <= w_frame_begin;
          if (w_frame_begin) begin
            r_arq_frame <= w_arq_next;
          end
          r_col <= r_col + COL_ONE;
          if (r_col == COL_OH_LAST) begin
            r_state <= S_PYLD;
          end
        end

        S_PYLD: begin
          // Without a client byte the slot pointer holds (stall).
          if (bus.i_pyld_valid) begin
            r_frame_data       <= bus.i_pyld_data;
            r_frame_data_valid <= 1'b1;
            r_row_cnt          <= r_row;
            r_col_cnt          <= r_col;
            r_col              <= r_col + COL_ONE;
            if (r_col == COL_PYLD_LAST) begin
              r_state <= S_STUFF;
            end
          end
        end

        S_STUFF: begin
          r_frame_data       <= 8'h00;
          r_frame_data_valid <= 1'b1;
          r_row_cnt          <= r_row;
          r_col_cnt          <= COL_STUFF;
          r_col              <= '0;
          if (r_row == ROW_LAST) begin
            // Frame boundary: the only place i_tx_en is honoured.
            r_row   <= '0;
            r_state <= bus.i_tx_en ? S_OH : S_IDLE;
          end else begin
            r_row   <= r_row + ROW_ONE;
            r_state <= S_OH;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_map.sv
// -----------------------------------------------------------------------------
// tb_frame_map
// Scoreboard bench for frame_map. Client bytes follow an incrementing pattern
// and are queued when the handshake accepts them; every valid line byte is
// compared against the expected frame position, overhead content, stuff byte
// or the next queued payload byte. Row 0 col 7 is expected to carry the frame
// index since reset when FRAME_MAP_MFAS_EN is defined, 0x00 otherwise.
// -----------------------------------------------------------------------------
module tb_frame_map;

  localparam int NUM_ROWS    = 4;
  localparam int ROW_LEN     = 1041;
  localparam int OH_COLS     = 16;
  localparam int FRAME_BYTES = NUM_ROWS * ROW_LEN;
  localparam int LONG_WAIT   = 6000;

  logic i_clk = 1'b0;
  logic i_rst;

  frame_map_if bus ();

  frame_map dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Bookkeeping and model state.
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] pyld_q[$];
  logic [7:0] pat;
  int         exp_row, exp_col;
  logic       arq_hold_m, arq_frame_m;
  int         frame_idx_m;
  int         frame_bytes;
  int         bytes_hist[$];
  int         fs_cyc[$];
  logic       last_valid;
  int         last_row, last_col;
  int         valid_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, row %0d col %0d)",
               tag, got, exp, cyc, exp_row, exp_col);
    end
  endtask

  function automatic logic [7:0] oh_exp(input int row, input int col);
    if (row != 0) return 8'h00;
    if (col < 3)  return 8'hF6;
    if (col < 6)  return 8'h28;
    if (col == 6) return {8{arq_frame_m}};
`ifdef FRAME_MAP_MFAS_EN
    if (col == 7) return 8'(frame_idx_m - 1);
`endif
    return 8'h00;
  endfunction

  // Negedge monitor: compares the byte registered at the previous edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge i_clk);
    cyc++;
    bus.i_arq_en_valid = 1'b0;
    last_valid = bus.o_frame_data_valid;
    if (bus.o_frame_data_valid === 1'b1) begin
      last_row = int'(bus.o_row_cnt);
      last_col = int'(bus.o_col_cnt);
      valid_seen++;
      frame_bytes++;
      check("row_label", bus.o_row_cnt, exp_row);
      check("col_label", bus.o_col_cnt, exp_col);
      check("frame_start", bus.o_frame_start, (exp_row == 0 && exp_col == 0));
      if (exp_row == 0 && exp_col == 0) begin
        fs_cyc.push_back(cyc);
        arq_frame_m = arq_hold_m;
        frame_idx_m++;
      end
      if (exp_col < OH_COLS) begin
        check("oh_data", bus.o_frame_data, oh_exp(exp_row, exp_col));
      end else if (exp_col == ROW_LEN - 1) begin
        check("stuff_data", bus.o_frame_data, 8'h00);
      end else if (pyld_q.size() == 0) begin
        check("pyld_available", 32'd0, 32'd1);
      end else begin
        e = pyld_q.pop_front();
        check("pyld_data", bus.o_frame_data, e);
      end
      if (exp_row == NUM_ROWS - 1 && exp_col == ROW_LEN - 1) begin
        bytes_hist.push_back(frame_bytes);
        frame_bytes = 0;
      end
      if (exp_col == ROW_LEN - 1) begin
        exp_col = 0;
        exp_row = (exp_row + 1) % NUM_ROWS;
      end else begin
        exp_col++;
      end
    end else begin
      check("frame_start_idle", bus.o_frame_start, 1'b0);
    end
    // Ready must reflect the slot now pointed at: payload columns only.
    check("pyld_ready", bus.o_pyld_ready,
          (!i_rst && exp_col >= OH_COLS && exp_col <= ROW_LEN - 2));
  endtask

  // Drives the current stimulus into the next edge and records accepted bytes.
  task automatic launch();
    bus.i_pyld_data = pat;
    if (i_rst) begin
      pyld_q.delete();
      exp_row     = 0;
      exp_col     = 0;
      arq_hold_m  = 1'b0;
      frame_idx_m = 0;
      frame_bytes = 0;
    end else if (bus.i_arq_en_valid) begin
      arq_hold_m = bus.i_arq_en;
    end
    #1;
    if (!i_rst && bus.o_pyld_ready === 1'b1 && bus.i_pyld_valid) begin
      pyld_q.push_back(pat);
      pat++;
    end
  endtask

  task automatic wait_pos(input int row, input int col, input int budget,
                          input string tag, output int n);
    bit hit;
    n = 0;
    do begin
      launch();
      tick();
      n++;
      hit = (last_valid === 1'b1) && (last_row == row) && (last_col == col);
    end while (!hit && n < budget);
    check({tag, "_reached"}, hit, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},  bus.o_frame_data, 8'h00);
    check({tag, "_valid"}, bus.o_frame_data_valid, 1'b0);
    check({tag, "_row"},   bus.o_row_cnt, 0);
    check({tag, "_col"},   bus.o_col_cnt, 0);
    check({tag, "_start"}, bus.o_frame_start, 1'b0);
    check({tag, "_ready"}, bus.o_pyld_ready, 1'b0);
  endtask

  initial begin
    int n;
    int vs0;

    i_rst              = 1'b1;
    bus.i_tx_en        = 1'b0;
    bus.i_pyld_data    = 8'h00;
    bus.i_pyld_valid   = 1'b0;
    bus.i_arq_en       = 1'b0;
    bus.i_arq_en_valid = 1'b0;
    pat         = 8'h00;
    exp_row     = 0;
    exp_col     = 0;
    arq_hold_m  = 1'b0;
    arq_frame_m = 1'b0;
    frame_idx_m = 0;
    frame_bytes = 0;
    valid_seen  = 0;
    last_valid  = 1'b0;
    last_row    = 0;
    last_col    = 0;

    // Reset state.
    tick();
    launch();
    tick();
    launch();
    tick();
    check_zero("reset");

    // Frame 1: continuous client, ARQ raised mid-frame (applies to frame 2).
    i_rst            = 1'b0;
    bus.i_tx_en      = 1'b1;
    bus.i_pyld_valid = 1'b1;
    wait_pos(0, 0, 10, "f1_start", n);
    check("f1_start_latency", n, 2);
    wait_pos(2, 300, LONG_WAIT, "f1_arq_point", n);
    bus.i_arq_en       = 1'b1;
    bus.i_arq_en_valid = 1'b1;
    wait_pos(0, 0, LONG_WAIT, "f2_start", n);
    check("f1_f2_period", fs_cyc[1] - fs_cyc[0], FRAME_BYTES);

    // Frame 2: 5-cycle client stall at row 1 col 100.
    wait_pos(1, 99, LONG_WAIT, "f2_stall_point", n);
    bus.i_pyld_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      launch();
      tick();
      check("stall_valid", bus.o_frame_data_valid, 1'b0);
      check("stall_col_hold", bus.o_col_cnt, 99);
    end
    bus.i_pyld_valid = 1'b1;
    launch();
    tick();
    check("stall_resume_col", bus.o_col_cnt, 100);

    // Frame 2: drop i_tx_en mid-frame; frame completes, then idles.
    wait_pos(2, 500, LONG_WAIT, "f2_txen_drop", n);
    bus.i_tx_en = 1'b0;
    wait_pos(3, 1040, LONG_WAIT, "f2_end", n);
    vs0 = valid_seen;
    for (int i = 0; i < 20; i++) begin
      launch();
      tick();
    end
    check("idle_no_bytes", valid_seen - vs0, 0);
    check("idle_valid", bus.o_frame_data_valid, 1'b0);

    // Frame 3: restart from IDLE (ARQ hold still set), reset at row 1 col 20.
    bus.i_tx_en = 1'b1;
    wait_pos(0, 0, 10, "f3_start", n);
    check("f3_start_latency", n, 2);
    wait_pos(1, 20, LONG_WAIT, "f3_rst_point", n);
    i_rst = 1'b1;
    launch();
    tick();
    check_zero("mid_rst");
    i_rst = 1'b0;

    // Frame 4: restarts at row 0 col 0 with ARQ cleared.
    wait_pos(0, 0, 10, "f4_start", n);
    check("f4_start_latency", n, 2);
    wait_pos(3, 1040, LONG_WAIT, "f4_end", n);
    // ARQ request in the same cycle as frame 5's start slot: new value used.
    bus.i_arq_en       = 1'b1;
    bus.i_arq_en_valid = 1'b1;
    wait_pos(0, 0, 4, "f5_start", n);
    check("f5_start_latency", n, 1);
    wait_pos(1, 0, LONG_WAIT, "f5_row1", n);
    check("f4_f5_period", fs_cyc[fs_cyc.size() - 1] - fs_cyc[fs_cyc.size() - 2], FRAME_BYTES);

    // Complete frames 1, 2 and 4 each carried the full byte count.
    check("complete_frames", bytes_hist.size(), 3);
    foreach (bytes_hist[i]) check("frame_byte_count", bytes_hist[i], FRAME_BYTES);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_map.md
Name: frame_map

Overview:
- Transmit-side mapper. Builds line frames from the client byte stream and the rec_tran ARQ request.
- Frame: NUM_ROWS rows x ROW_LEN columns. Columns 0..OH_COLS-1 carry overhead. Columns OH_COLS..ROW_LEN-2 carry payload. Column ROW_LEN-1 is a stuff byte (0x00).
- Sits between the client source and the line serializer. The receive-side demapper strips exactly this format.

Parameters:
- NUM_ROWS, 4, rows per frame; row counter is 2 bits.
- ROW_LEN, 1041, columns per row (0..1040); column counter is 11 bits.
- OH_COLS, 16, overhead columns per row.
- FAS_A, 8'hF6, FAS byte sent in row 0, cols 0..2.
- FAS_B, 8'h28, FAS byte sent in row 0, cols 3..5.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_tx_en  in  1  start/continue framing; sampled only at frame boundaries.
- i_pyld_data  in  8  client payload byte.
- i_pyld_valid  in  1  client byte present.
- o_pyld_ready  out  1  combinational; mapper consumes the client byte this cycle when ready & valid.
- i_arq_en  in  1  ARQ request from rec_tran.
- i_arq_en_valid  in  1  qualifier for i_arq_en.
- o_frame_data  out  8  line byte.
- o_frame_data_valid  out  1  line byte qualifier.
- o_row_cnt  out  2  row of the byte currently on o_frame_data.
- o_col_cnt  out  11  column of the byte currently on o_frame_data.
- o_frame_start  out  1  one-cycle pulse with the row 0 / col 0 byte.

Behaviour:
- Reset values: o_frame_data=0, o_frame_data_valid=0, o_row_cnt=0, o_col_cnt=0, o_frame_start=0; internal row/col=0, arq_hold=0, arq_frame=0; state IDLE.
- Reset mid-frame aborts immediately. The next frame restarts at row 0, col 0.
- ARQ latch: when i_arq_en_valid=1, arq_hold <= i_arq_en. Value persists until the next valid.
  - At each frame start, arq_frame <= arq_hold, so the ARQ value is constant within a frame.
  - If i_arq_en_valid occurs in the same cycle as frame start, the new value is used.
- State machine (internal row/col point at the next slot to emit):
  - IDLE: outputs invalid. Go to OH at row 0, col 0 when i_tx_en=1.
  - OH: cols 0..OH_COLS-1. One byte emitted per cycle, unconditionally. After col OH_COLS-1, go to PYLD.
  - PYLD: cols OH_COLS..ROW_LEN-2. o_pyld_ready=1.
    - A byte is emitted only on i_pyld_valid=1; otherwise the counters hold and o_frame_data_valid=0 (stall).
    - After col ROW_LEN-2 is accepted, go to STUFF.
  - STUFF: col ROW_LEN-1. Emit 0x00 unconditionally.
    - If row < NUM_ROWS-1: row+1, col 0, go to OH.
    - If last row: check i_tx_en. If 1, go to OH at row 0 (next frame). If 0, go to IDLE.
- i_tx_en deassert mid-frame has no effect until the frame completes.
- o_pyld_ready=0 in IDLE, OH, STUFF and during reset.
- Overhead contents:
  - Row 0: cols 0..2 = FAS_A; cols 3..5 = FAS_B; col 6 = {8{arq_frame}} (0xFF or 0x00).
  - All other overhead bytes = 0x00.
- Latency: every output is registered, 1 cycle after slot selection.
  - o_row_cnt/o_col_cnt label the byte they accompany.
  - o_frame_start=1 with the row 0 / col 0 byte.
- Output data is held when o_frame_data_valid=0.
- Payload bytes per frame: NUM_ROWS*(ROW_LEN-OH_COLS-1) = 4096 with defaults.
- Counter wrap: col ROW_LEN-1 -> 0; row NUM_ROWS-1 -> 0. No other values are reachable.

Optional Feature:
- Macro: FRAME_MAP_MFAS_EN.
- Defined: an 8-bit multiframe counter increments at each frame start (wraps 255->0, reset 0). Its value is sent in row 0, col 7. The first frame after reset carries 0x00.
- Undefined: row 0, col 7 = 0x00; no counter is present.

Test Plan:
- Reset, i_tx_en=1, client always valid with an incrementing byte pattern from 0x00 -> row 0 cols 0..5 = F6 F6 F6 28 28 28; col 6 = 0x00; payload row 0 col 16 = 0x00, col 1039 = 0xFF; col 1040 = 0x00; 4164 valid bytes per frame; o_frame_start every 4164 cycles.
- i_arq_en=1 with i_arq_en_valid pulsed mid-frame -> current frame col 6 stays 0x00; next frame row 0 col 6 = 0xFF; rows 1..3 col 6 = 0x00.
- Client valid deasserted for 5 cycles at row 1 col 100 -> o_frame_data_valid low for 5 cycles; col counter holds at 100; no byte lost; o_pyld_ready stays 0 throughout OH and STUFF.
- i_tx_en dropped at row 2 col 500 -> frame completes through row 3 col 1040, then IDLE; outputs invalid; re-raising i_tx_en restarts at row 0 col 0 with o_frame_start.
- i_rst pulsed at row 1 col 20 -> next cycle all outputs 0; after release, frame restarts at row 0 col 0; arq_hold cleared.
- With FRAME_MAP_MFAS_EN defined, 3 consecutive frames -> row 0 col 7 = 0x00, 0x01, 0x02.
